window_sample_feeder: RTL
=========================

// Module: window_sample_feeder
// PURPOSE
//  Sliding-window sample buffer that produces the (first, last) sample pairs consumed by the
//  running-energy block: first = newest sample entering the window, last = sample leaving it.
//  Sits between the AVS sample source and the energy accumulator; keeps the accumulator's
//  running sum exact by emitting zero for 'last' while priming and draining on flush.
// PARAMETERS
//  WINDOW_SIZE   16  samples in window (energy block divides by this; windowSize+1 there)
//  SAMPLE_WIDTH  16  signed sample width
//  ADDR_WIDTH    4   ceil(log2(WINDOW_SIZE)); WINDOW_SIZE must be a power of two
// PORTS
//  clock         in   1             rising-edge clock
//  reset         in   1             synchronous, active-high
//  sample_in     in   SAMPLE_WIDTH  signed input sample
//  sample_valid  in   1             sample_in valid this cycle
//  sample_ready  out  1             block accepts samples (low while flushing)
//  flush         in   1             drain window so downstream sum returns to zero
//  first         out  SAMPLE_WIDTH  signed newest sample (0 during flush)
//  last          out  SAMPLE_WIDTH  signed sample leaving window (0 while priming)
//  pair_valid    out  1             first/last valid, one-cycle pulse per pair
//  window_full   out  1             WINDOW_SIZE samples held
//  fill_count    out  ADDR_WIDTH+1  samples currently held, 0..WINDOW_SIZE
// BEHAVIOUR
//  Reset: first=0, last=0, pair_valid=0, sample_ready=1, window_full=0, fill_count=0,
//   wr_ptr=0, state=EMPTY. Buffer RAM not cleared; fill_count gates all reads.
//  Storage: circular RAM[WINDOW_SIZE], wr_ptr wraps WINDOW_SIZE-1 -> 0.
//  States: EMPTY (fill=0), PRIMING (0<fill<N), FULL (fill=N), FLUSH.
//  Accept: sample_valid & sample_ready & ~flush. Next cycle: pair_valid=1, first=sample_in,
//   last = RAM[wr_ptr] (pre-write value) if FULL else 0; RAM[wr_ptr]<=sample_in; wr_ptr++;
//   fill_count++ unless already N. Latency 1 cycle, throughput 1 sample/cycle, no back-pressure
//   outside FLUSH. Read-before-write on same address is required.
//  Transitions: EMPTY->PRIMING on accept; PRIMING->FULL when fill reaches N (N=1: EMPTY->FULL);
//   FULL stays FULL on accept; any non-FLUSH state with flush=1 and fill>0 -> FLUSH.
//  flush in EMPTY: no-op, no pairs, stays EMPTY.
//  flush & sample_valid same cycle: flush wins, sample dropped (not written, no pair).
//  FLUSH: sample_ready=0; rd_ptr starts at wr_ptr-fill_count (mod N), one pair per cycle,
//   oldest first: first=0, last=RAM[rd_ptr], pair_valid=1; fill_count-- per pair;
//   window_full=0 from first flush cycle. After fill_count pairs -> EMPTY, sample_ready=1
//   next cycle. flush held high during/after FLUSH does not restart it (edge-free: only
//   sampled in non-FLUSH states with fill>0). sample_valid during FLUSH ignored.
//  Idle cycles: pair_valid=0; first/last hold last values.
//  window_full = (state==FULL). Reset mid-FLUSH or mid-stream: immediate return to reset
//   values, no further pairs.
//  Invariant: sum of (first^2 - last^2) over all emitted pairs since reset = sum of squares of
//   samples currently held (0 after FLUSH completes).
// TESTING
//  Priming: 16 samples 1..16 back-to-back -> pairs (1,0)..(16,0), window_full high after 16th.
//  Steady: then 17,18 -> pairs (17,1),(18,2); pair_valid 1 cycle after each accept.
//  Wrap/gaps: 40 samples with random idle gaps -> last equals sample from 16 accepts earlier.
//  Partial flush: 5 samples -7,3,-32768,32767,0 then flush -> 5 pairs (0,-7),(0,3),(0,-32768),
//   (0,32767),(0,0), sample_ready low 5 cycles, fill_count 0, then priming restarts (last=0).
//  Collision: flush+sample_valid same cycle when FULL -> sample dropped, 16 drain pairs only.
//  Reset mid-flush after 3 pairs -> pair_valid 0 next cycle, fill_count 0, EMPTY.

Source files
------------

// File: rtl/window_sample_feeder.sv
// Sliding-window sample buffer feeding (first, last) pairs to the running-energy block.
// 'first' is the newest sample entering the window and 'last' is the sample leaving it.
// 'last' is zero while the window primes. A flush drains the window oldest-first with
// 'first' held at zero, which brings the downstream running sum back to zero.
module window_sample_feeder #(
  parameter int WINDOW_SIZE  = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic                           flush,
  output logic signed [SAMPLE_WIDTH-1:0] first,
  output logic signed [SAMPLE_WIDTH-1:0] last,
  output logic                           pair_valid,
  output logic                           window_full,
  output logic [ADDR_WIDTH:0]            fill_count
);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PRIMING = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(WINDOW_SIZE);

  logic signed [SAMPLE_WIDTH-1:0] r_ram [WINDOW_SIZE];
  logic [1:0]                     r_state;
  logic [ADDR_WIDTH-1:0]          r_wr_ptr;
  logic [ADDR_WIDTH-1:0]          r_rd_ptr;
  logic [ADDR_WIDTH:0]            r_fill;
  logic signed [SAMPLE_WIDTH-1:0] r_first;
  logic signed [SAMPLE_WIDTH-1:0] r_last;
  logic                           r_pair_valid;

  logic w_accept;
  logic w_flush_start;
  logic w_will_be_full;

  // Accept/flush decode; flush has priority over a same-cycle sample.
  always_comb begin
    sample_ready   = (r_state != S_FLUSH);
    w_accept       = sample_valid && sample_ready && !flush;
    w_flush_start  = flush && (r_state != S_FLUSH) && (r_fill != '0);
    w_will_be_full = (r_state == S_FULL) || ((r_fill + 1'b1) == FILL_MAX);
  end

  // Sample storage: uncleared circular RAM, written only on accept.
  always_ff @(posedge clock) begin
    if (!reset && w_accept) begin
      r_ram[r_wr_ptr] <= sample_in;
    end
  end

  // Window control, pair generation and flush drain sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_EMPTY;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_first      <= '0;
      r_last       <= '0;
      r_pair_valid <= 1'b0;
    end else begin
      r_pair_valid <= 1'b0;
      case (r_state)
        S_FLUSH: begin
          r_pair_valid <= 1'b1;
          r_first      <= '0;
          r_last       <= r_ram[r_rd_ptr];
          r_rd_ptr     <= r_rd_ptr + 1'b1;
          r_fill       <= r_fill - 1'b1;
          if (r_fill == (ADDR_WIDTH+1)'(1)) begin
            r_state <= S_EMPTY;
          end
        end
        default: begin
          if (w_flush_start) begin
            // Oldest held sample sits fill_count slots behind the write pointer (mod N);
            // a full window truncates to an offset of zero, i.e. the write pointer itself.
            r_state  <= S_FLUSH;
            r_rd_ptr <= r_wr_ptr - r_fill[ADDR_WIDTH-1:0];
          end else if (w_accept) begin
            r_pair_valid <= 1'b1;
            r_first      <= sample_in;
            // Read of the outgoing sample sees the pre-write RAM contents.
            r_last       <= (r_state == S_FULL) ? r_ram[r_wr_ptr] : '0;
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            if (r_fill != FILL_MAX) begin
              r_fill <= r_fill + 1'b1;
            end
            r_state <= w_will_be_full ? S_FULL : S_PRIMING;
          end
        end
      endcase
    end
  end

  assign first       = r_first;
  assign last        = r_last;
  assign pair_valid  = r_pair_valid;
  assign window_full = (r_state == S_FULL);
  assign fill_count  = r_fill;

endmodule
